// File: rtl/out_port_fifo_2ch_pkg.sv
// Shared defaults and channel encoding for the two-channel output-port buffer.
package out_port_fifo_2ch_pkg;

    localparam int RAT_IO_WIDTH       = 8;
    localparam int RAT_OUT_FIFO_DEPTH = 4;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

endpackage : out_port_fifo_2ch_pkg

// File: rtl/out_port_fifo.sv
// Single-channel output FIFO: strobe-driven push, VALID/READY pop, sticky overflow.
module out_port_fifo
    import out_port_fifo_2ch_pkg::*;
#(
    parameter int N     = RAT_IO_WIDTH,
    parameter int DEPTH = RAT_OUT_FIFO_DEPTH
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         WR,
    input  logic [N-1:0] WDATA,
    input  logic         RD_RDY,
    output logic         VALID,
    output logic [N-1:0] RDATA,
    output logic         FULL,
    output logic         OVF,
    input  logic         CLR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  rdata_q, rdata_d;

    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;

    // Next-state computation; outputs are precomputed from the next state so they leave flops.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        pop_s     = RD_RDY & valid_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok_s = WR & (~full_q | pop_s);
        drop_s    = WR & full_q & ~pop_s;

        if (push_ok_s) begin
            mem_d[wptr_q] = WDATA;
            wptr_d        = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        valid_d = (count_d != CW'(0));
        full_d  = (count_d == CW'(DEPTH));
        if (valid_d) begin
            rdata_d = mem_d[rptr_d];
        end else begin
            rdata_d = {N{1'b0}};
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_q   <= '{default: {N{1'b0}}};
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdata_q <= {N{1'b0}};
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign VALID = valid_q;
    assign RDATA = rdata_q;
    assign FULL  = full_q;
    assign OVF   = ovf_q;

endmodule : out_port_fifo

// File: rtl/out_port_fifo_2ch.sv
// Two independent output FIFOs fed from the SEL-steered demux legs on each IO strobe.
module out_port_fifo_2ch
    import out_port_fifo_2ch_pkg::*;
#(
    parameter int n     = RAT_IO_WIDTH,
    parameter int DEPTH = RAT_OUT_FIFO_DEPTH
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IO_STRB,
    input  logic         SEL,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    input  logic         CLR_OVF,
    output logic         VALID0,
    input  logic         READY0,
    output logic [n-1:0] DOUT0,
    output logic         VALID1,
    input  logic         READY1,
    output logic [n-1:0] DOUT1,
    output logic         FULL0,
    output logic         FULL1,
    output logic         OVF0,
    output logic         OVF1
);

    logic wr0_s;
    logic wr1_s;

    // Case equality keeps an unknown SEL from pushing into either channel.
    assign wr0_s = IO_STRB & (SEL === CH0);
    assign wr1_s = IO_STRB & (SEL === CH1);

    out_port_fifo #(.N(n), .DEPTH(DEPTH)) u_ch0 (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR      (wr0_s),
        .WDATA   (D0),
        .RD_RDY  (READY0),
        .VALID   (VALID0),
        .RDATA   (DOUT0),
        .FULL    (FULL0),
        .OVF     (OVF0),
        .CLR_OVF (CLR_OVF)
    );

    out_port_fifo #(.N(n), .DEPTH(DEPTH)) u_ch1 (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR      (wr1_s),
        .WDATA   (D1),
        .RD_RDY  (READY1),
        .VALID   (VALID1),
        .RDATA   (DOUT1),
        .FULL    (FULL1),
        .OVF     (OVF1),
        .CLR_OVF (CLR_OVF)
    );

endmodule : out_port_fifo_2ch

// File: tb/tb_out_port_fifo_2ch.sv
// Directed bench for out_port_fifo_2ch with hand-computed expectations.
module tb_out_port_fifo_2ch;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IO_STRB = 1'b0;
    logic       SEL = 1'b0;
    logic [7:0] D0 = 8'h00;
    logic [7:0] D1 = 8'h00;
    logic       CLR_OVF = 1'b0;
    logic       READY0 = 1'b0;
    logic       READY1 = 1'b0;
    logic       VALID0, VALID1, FULL0, FULL1, OVF0, OVF1;
    logic [7:0] DOUT0, DOUT1;

    int vecs = 0;
    int errs = 0;

    out_port_fifo_2ch dut (
        .CLK(CLK), .RST_N(RST_N), .IO_STRB(IO_STRB), .SEL(SEL),
        .D0(D0), .D1(D1), .CLR_OVF(CLR_OVF),
        .VALID0(VALID0), .READY0(READY0), .DOUT0(DOUT0),
        .VALID1(VALID1), .READY1(READY1), .DOUT1(DOUT1),
        .FULL0(FULL0), .FULL1(FULL1), .OVF0(OVF0), .OVF1(OVF1)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sel, input logic [7:0] d);
        IO_STRB = 1'b1;
        SEL = sel;
        D0 = sel ? 8'h00 : d;
        D1 = sel ? d : 8'h00;
        tick();
        IO_STRB = 1'b0;
        D0 = 8'h00;
        D1 = 8'h00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v0"}, {31'd0, VALID0}, 32'd0);
        chk({tag, "_v1"}, {31'd0, VALID1}, 32'd0);
        chk({tag, "_d0"}, {24'd0, DOUT0}, 32'd0);
        chk({tag, "_d1"}, {24'd0, DOUT1}, 32'd0);
        chk({tag, "_f0"}, {31'd0, FULL0}, 32'd0);
        chk({tag, "_f1"}, {31'd0, FULL1}, 32'd0);
        chk({tag, "_o0"}, {31'd0, OVF0}, 32'd0);
        chk({tag, "_o1"}, {31'd0, OVF1}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q [$];

        // 1. Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            IO_STRB = 1'($urandom_range(1, 0));
            SEL     = 1'($urandom_range(1, 0));
            D0      = 8'($urandom);
            D1      = 8'($urandom);
            CLR_OVF = 1'($urandom_range(1, 0));
            READY0  = 1'($urandom_range(1, 0));
            READY1  = 1'($urandom_range(1, 0));
            tick();
        end
        chk_all_zero("rst");
        IO_STRB = 1'b0; CLR_OVF = 1'b0; READY0 = 1'b0; READY1 = 1'b0;
        D0 = 8'h00; D1 = 8'h00;
        RST_N = 1'b1;
        tick();
        chk_all_zero("post_rst");
        push(1'b0, 8'hA5);
        chk("lat_v0", {31'd0, VALID0}, 32'd1);
        chk("lat_d0", {24'd0, DOUT0}, 32'hA5);
        chk("lat_v1", {31'd0, VALID1}, 32'd0);
        READY0 = 1'b1;
        tick();
        READY0 = 1'b0;
        chk("pop_v0", {31'd0, VALID0}, 32'd0);
        chk("pop_d0", {24'd0, DOUT0}, 32'd0);

        // 2. Fill ch1, overflow, drain
        push(1'b1, 8'h11);
        push(1'b1, 8'h22);
        push(1'b1, 8'h33);
        chk("fill3_full1", {31'd0, FULL1}, 32'd0);
        push(1'b1, 8'h44);
        chk("fill_full1", {31'd0, FULL1}, 32'd1);
        chk("fill_ovf1", {31'd0, OVF1}, 32'd0);
        push(1'b1, 8'h55);
        chk("ovf_ovf1", {31'd0, OVF1}, 32'd1);
        chk("ovf_full1", {31'd0, FULL1}, 32'd1);
        chk("ovf_d1", {24'd0, DOUT1}, 32'h11);
        chk("ovf_ovf0", {31'd0, OVF0}, 32'd0);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        READY1 = 1'b1;
        foreach (exp_q[i]) begin
            chk("drain_v1", {31'd0, VALID1}, 32'd1);
            chk("drain_d1", {24'd0, DOUT1}, {24'd0, exp_q[i]});
            tick();
        end
        READY1 = 1'b0;
        chk("drain_end_v1", {31'd0, VALID1}, 32'd0);
        chk("drain_end_d1", {24'd0, DOUT1}, 32'd0);
        chk("drain_ovf1_sticky", {31'd0, OVF1}, 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("clr_ovf1", {31'd0, OVF1}, 32'd0);

        // 3. Wrap: push every cycle with READY0 held high
        READY0 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            push(1'b0, 8'(i));
            chk("wrap_v0", {31'd0, VALID0}, 32'd1);
            chk("wrap_d0", {24'd0, DOUT0}, i);
            chk("wrap_full0", {31'd0, FULL0}, 32'd0);
        end
        tick();
        READY0 = 1'b0;
        chk("wrap_end_v0", {31'd0, VALID0}, 32'd0);
        chk("wrap_ovf0", {31'd0, OVF0}, 32'd0);

        // 4. Full ch1 with simultaneous pop and push
        push(1'b1, 8'h61);
        push(1'b1, 8'h62);
        push(1'b1, 8'h63);
        push(1'b1, 8'h64);
        chk("fp_full1_pre", {31'd0, FULL1}, 32'd1);
        READY1 = 1'b1;
        push(1'b1, 8'h99);
        chk("fp_ovf1", {31'd0, OVF1}, 32'd0);
        chk("fp_full1", {31'd0, FULL1}, 32'd1);
        exp_q = '{8'h62, 8'h63, 8'h64, 8'h99};
        foreach (exp_q[i]) begin
            chk("fp_d1", {24'd0, DOUT1}, {24'd0, exp_q[i]});
            tick();
        end
        READY1 = 1'b0;
        chk("fp_end_v1", {31'd0, VALID1}, 32'd0);

        // 5. Independence: ch0 stalled with 3 entries, ch1 streams
        push(1'b0, 8'hA1);
        push(1'b0, 8'hA2);
        push(1'b0, 8'hA3);
        READY1 = 1'b1;
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        foreach (exp_q[i]) begin
            push(1'b1, exp_q[i]);
            chk("ind_d1", {24'd0, DOUT1}, {24'd0, exp_q[i]});
            chk("ind_d0", {24'd0, DOUT0}, 32'hA1);
        end
        tick();
        READY1 = 1'b0;
        chk("ind_end_v1", {31'd0, VALID1}, 32'd0);
        chk("ind_v0", {31'd0, VALID0}, 32'd1);
        chk("ind_full0", {31'd0, FULL0}, 32'd0);
        push(1'b0, 8'hA4);
        chk("ind_full0_4", {31'd0, FULL0}, 32'd1);
        CLR_OVF = 1'b1;
        push(1'b0, 8'hEE);
        CLR_OVF = 1'b0;
        chk("setwins_ovf0", {31'd0, OVF0}, 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("clr_ovf0", {31'd0, OVF0}, 32'd0);
        READY0 = 1'b1;
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        foreach (exp_q[i]) begin
            chk("ind_drain_d0", {24'd0, DOUT0}, {24'd0, exp_q[i]});
            tick();
        end
        READY0 = 1'b0;
        chk("ind_drain_v0", {31'd0, VALID0}, 32'd0);

        // 6. Asynchronous reset mid-drain
        push(1'b1, 8'hC1);
        push(1'b1, 8'hC2);
        push(1'b0, 8'hD1);
        READY1 = 1'b1;
        tick();
        chk("ar_pre_v1", {31'd0, VALID1}, 32'd1);
        chk("ar_pre_d1", {24'd0, DOUT1}, 32'hC2);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all_zero("ar");
        tick();
        RST_N = 1'b1;
        READY0 = 1'b1;
        tick();
        tick();
        chk("ar_post_v0", {31'd0, VALID0}, 32'd0);
        chk("ar_post_v1", {31'd0, VALID1}, 32'd0);
        READY0 = 1'b0;
        READY1 = 1'b0;
        push(1'b1, 8'h7E);
        chk("ar_new_v1", {31'd0, VALID1}, 32'd1);
        chk("ar_new_d1", {24'd0, DOUT1}, 32'h7E);
        chk("ar_new_v0", {31'd0, VALID0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_out_port_fifo_2ch
